// File: rtl/fir_param_mac.sv
// fir_param_mac: FIR engine whose taps, tap count, block length and output
// scaling are programmed over AXI-Lite. Samples stream in/out on AXI-Stream.
// A single shared multiplier performs one MAC per cycle; each result is
// arithmetically shifted right and saturated to the sample width.
module fir_param_mac #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int MAX_TAPS    = 32,
  parameter int ACC_WIDTH   = 2*pDATA_WIDTH + $clog2(MAX_TAPS)
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   ss_tvalid,
  output logic                   ss_tready,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  output logic                   sm_tvalid,
  input  logic                   sm_tready,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast
);

  localparam int IDX_W = $clog2(MAX_TAPS);
  localparam int TN_W  = IDX_W + 1;
  localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL  = pADDR_WIDTH'(32'h00);
  localparam logic [pADDR_WIDTH-1:0] ADDR_LEN   = pADDR_WIDTH'(32'h10);
  localparam logic [pADDR_WIDTH-1:0] ADDR_TNUM  = pADDR_WIDTH'(32'h14);
  localparam logic [pADDR_WIDTH-1:0] ADDR_SHIFT = pADDR_WIDTH'(32'h18);
  localparam logic [pADDR_WIDTH-1:0] TAP_BASE   = pADDR_WIDTH'(32'h80);
  localparam logic [pADDR_WIDTH-1:0] TAP_END    = pADDR_WIDTH'(32'h80 + 4*MAX_TAPS);
  localparam logic [TN_W-1:0]        TN_MAX     = TN_W'(MAX_TAPS);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX =
    {{(ACC_WIDTH-pDATA_WIDTH+1){1'b0}}, {(pDATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN =
    {{(ACC_WIDTH-pDATA_WIDTH+1){1'b1}}, {(pDATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_IN = 2'd1,
    S_MAC     = 2'd2,
    S_OUT     = 2'd3
  } state_t;

  // Clamp a shifted accumulator into the signed sample range.
  function automatic logic [pDATA_WIDTH-1:0] sat_out(input logic signed [ACC_WIDTH-1:0] v);
    if (v > ACC_MAX) begin
      sat_out = {1'b0, {(pDATA_WIDTH-1){1'b1}}};
    end else if (v < ACC_MIN) begin
      sat_out = {1'b1, {(pDATA_WIDTH-1){1'b0}}};
    end else begin
      sat_out = v[pDATA_WIDTH-1:0];
    end
  endfunction

  state_t                        r_state;
  logic                          r_awready, r_arready, r_rvalid;
  logic [pDATA_WIDTH-1:0]        r_rdata;
  logic signed [pDATA_WIDTH-1:0] r_taps [MAX_TAPS];
  logic signed [pDATA_WIDTH-1:0] r_d    [MAX_TAPS];
  logic [pDATA_WIDTH-1:0]        r_data_length, r_out_cnt;
  logic [TN_W-1:0]               r_tap_num;
  logic [4:0]                    r_out_shift;
  logic                          r_ap_done, r_ap_idle;
  logic                          r_ss_tready, r_sm_tvalid, r_sm_tlast;
  logic [pDATA_WIDTH-1:0]        r_sm_tdata;
  logic [IDX_W-1:0]              r_k;
  logic signed [ACC_WIDTH-1:0]   r_acc;

  logic                          w_wr_hs, w_cfg_wr, w_ap_start, w_rd_hs, w_rd_ctrl;
  logic                          w_wr_is_tap, w_rd_is_tap;
  logic [pADDR_WIDTH-1:0]        w_wr_off, w_rd_off;
  logic [IDX_W-1:0]              w_wr_idx, w_rd_idx;
  logic [pDATA_WIDTH-1:0]        w_rd_data;
  logic signed [2*pDATA_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]   w_acc_next, w_shifted;
  logic                          w_last_k, w_last_beat, w_ss_hs, w_sm_hs;

  assign awready   = r_awready;
  assign wready    = r_awready;
  assign arready   = r_arready;
  assign rvalid    = r_rvalid;
  assign rdata     = r_rdata;
  assign ss_tready = r_ss_tready;
  assign sm_tvalid = r_sm_tvalid;
  assign sm_tdata  = r_sm_tdata;
  assign sm_tlast  = r_sm_tlast;

  assign w_wr_hs     = awvalid && wvalid && r_awready;
  assign w_cfg_wr    = w_wr_hs && r_ap_idle;
  assign w_ap_start  = w_wr_hs && (awaddr == ADDR_CTRL) && wdata[0] && (r_state == S_IDLE);
  assign w_wr_is_tap = (awaddr >= TAP_BASE) && (awaddr < TAP_END);
  assign w_wr_off    = awaddr - TAP_BASE;
  assign w_wr_idx    = IDX_W'(w_wr_off >> 2);
  assign w_rd_hs     = arvalid && r_arready;
  assign w_rd_ctrl   = w_rd_hs && (araddr == ADDR_CTRL);
  assign w_rd_is_tap = (araddr >= TAP_BASE) && (araddr < TAP_END);
  assign w_rd_off    = araddr - TAP_BASE;
  assign w_rd_idx    = IDX_W'(w_rd_off >> 2);

  assign w_prod      = r_taps[r_k] * r_d[r_k];
  assign w_acc_next  = r_acc + {{(ACC_WIDTH-2*pDATA_WIDTH){w_prod[2*pDATA_WIDTH-1]}}, w_prod};
  assign w_shifted   = w_acc_next >>> r_out_shift;
  assign w_last_k    = ({1'b0, r_k} == (r_tap_num - TN_W'(1)));
  assign w_last_beat = ((r_out_cnt + pDATA_WIDTH'(1)) == r_data_length);
  assign w_ss_hs     = ss_tvalid && r_ss_tready;
  assign w_sm_hs     = r_sm_tvalid && sm_tready;

  // Read-data mux; tap reads are masked with all-ones while a block runs.
  always_comb begin
    w_rd_data = '0;
    if (araddr == ADDR_CTRL) begin
      w_rd_data = {{(pDATA_WIDTH-3){1'b0}}, r_ap_idle, r_ap_done, 1'b0};
    end else if (araddr == ADDR_LEN) begin
      w_rd_data = r_data_length;
    end else if (araddr == ADDR_TNUM) begin
      w_rd_data = {{(pDATA_WIDTH-TN_W){1'b0}}, r_tap_num};
    end else if (araddr == ADDR_SHIFT) begin
      w_rd_data = {{(pDATA_WIDTH-5){1'b0}}, r_out_shift};
    end else if (w_rd_is_tap) begin
      w_rd_data = r_ap_idle ? r_taps[w_rd_idx] : {pDATA_WIDTH{1'b1}};
    end else begin
      w_rd_data = '0;
    end
  end

  // Pulse awready/wready for one cycle once both write valids are seen.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_awready <= 1'b0;
    end else if (r_awready) begin
      r_awready <= 1'b0;
    end else begin
      r_awready <= awvalid && wvalid;
    end
  end

  // Read channel: one-cycle arready, then registered rdata held until rready.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= arvalid && !r_rvalid && !r_arready;
      if (w_rd_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
      end else if (r_rvalid && rready) begin
        r_rvalid <= 1'b0;
      end else begin
        r_rvalid <= r_rvalid;
      end
    end
  end

  // Configuration registers; writable only while the engine is idle.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_data_length <= '0;
      r_tap_num     <= TN_MAX;
      r_out_shift   <= 5'd0;
      for (int i = 0; i < MAX_TAPS; i++) r_taps[i] <= '0;
    end else if (w_cfg_wr) begin
      if (awaddr == ADDR_LEN) begin
        r_data_length <= wdata;
      end else if (awaddr == ADDR_TNUM) begin
        if (wdata == '0)                            r_tap_num <= TN_W'(1);
        else if (wdata > pDATA_WIDTH'(MAX_TAPS))    r_tap_num <= TN_MAX;
        else                                        r_tap_num <= TN_W'(wdata);
      end else if (awaddr == ADDR_SHIFT) begin
        r_out_shift <= wdata[4:0];
      end else if (w_wr_is_tap) begin
        r_taps[w_wr_idx] <= wdata;
      end
    end
  end

  // Control FSM and datapath: accept sample, run tap_num MACs, present result.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_state     <= S_IDLE;
      r_ap_idle   <= 1'b1;
      r_ap_done   <= 1'b0;
      r_ss_tready <= 1'b0;
      r_sm_tvalid <= 1'b0;
      r_sm_tlast  <= 1'b0;
      r_sm_tdata  <= '0;
      r_out_cnt   <= '0;
      r_k         <= '0;
      r_acc       <= '0;
      for (int i = 0; i < MAX_TAPS; i++) r_d[i] <= '0;
    end else begin
      if (w_rd_ctrl) r_ap_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_ap_start) begin
            if (r_data_length != '0) begin
              for (int i = 0; i < MAX_TAPS; i++) r_d[i] <= '0;
              r_out_cnt   <= '0;
              r_ap_done   <= 1'b0;
              r_ap_idle   <= 1'b0;
              r_ss_tready <= 1'b1;
              r_state     <= S_WAIT_IN;
            end else begin
              r_ap_done <= 1'b1;
            end
          end
        end
        S_WAIT_IN: begin
          if (w_ss_hs) begin
            for (int i = MAX_TAPS-1; i > 0; i--) r_d[i] <= r_d[i-1];
            r_d[0]      <= ss_tdata;
            r_acc       <= '0;
            r_k         <= '0;
            r_ss_tready <= 1'b0;
            r_state     <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= w_acc_next;
          r_k   <= r_k + IDX_W'(1);
          if (w_last_k) begin
            r_sm_tdata  <= sat_out(w_shifted);
            r_sm_tvalid <= 1'b1;
            r_sm_tlast  <= w_last_beat;
            r_state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (w_sm_hs) begin
            r_sm_tvalid <= 1'b0;
            r_sm_tlast  <= 1'b0;
            r_out_cnt   <= r_out_cnt + pDATA_WIDTH'(1);
            if (r_sm_tlast) begin
              r_ap_done <= 1'b1;
              r_ap_idle <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_ss_tready <= 1'b1;
              r_state     <= S_WAIT_IN;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_ap_idle   <= 1'b1;
          r_ss_tready <= 1'b0;
          r_sm_tvalid <= 1'b0;
          r_sm_tlast  <= 1'b0;
        end
      endcase
    end
  end

endmodule
